// File: rtl/fetch_line_queue_if.sv
// Fetch front-end bundle: redirect input, SRAM line-read port and instruction-window output.
// Handshakes: a read is accepted when sram_cs && sram_gnt in the same cycle; an instruction is consumed when inst_valid && inst_ready in the same cycle.
interface fetch_line_queue_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        sram_cs;
  logic [28:0] sram_addr;
  logic        sram_gnt;
  logic [63:0] sram_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_pc;
  logic [31:0] inst_win;
  logic        inst_is16;

  modport master (
    input  redirect_valid, redirect_pc, sram_gnt, sram_rdata, inst_ready,
    output sram_cs, sram_addr, inst_valid, inst_pc, inst_win, inst_is16
  );

  modport slave (
    output redirect_valid, redirect_pc, sram_gnt, sram_rdata, inst_ready,
    input  sram_cs, sram_addr, inst_valid, inst_pc, inst_win, inst_is16
  );
endinterface

// File: rtl/fetch_line_queue.sv
// Sequential 64-bit line prefetcher with a small line queue and a PC-aligned 32-bit instruction window.
// Straddling 32-bit instructions are assembled from the head and next queued lines.
module fetch_line_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input logic               clk,
  input logic               rstn,
  fetch_line_queue_if.master bus
);
  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] QD = CW'(QDEPTH);

  logic [31:0]   pc;
  logic [28:0]   fetch_addr;
  logic [63:0]   q_data [QDEPTH];
  logic [28:0]   q_addr [QDEPTH];
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          in_flight;
  logic [28:0]   flight_addr;
  logic          started;

  logic [PW-1:0] nx_ptr;
  logic [PW-1:0] wr_ptr;
  logic [63:0]   head;
  logic [63:0]   next;
  logic [28:0]   head_addr;
  logic          head_ok;
  logic          next_ok;
  logic [31:0]   win;
  logic          is16;
  logic          grant;
  logic          push;
  logic          consume;
  logic          pop;
  logic [31:0]   pc_step;

  assign nx_ptr    = rd_ptr + PW'(1);
  assign wr_ptr    = rd_ptr + count[PW-1:0];
  assign head      = q_data[rd_ptr];
  assign next      = q_data[nx_ptr];
  assign head_addr = q_addr[rd_ptr];
  assign head_ok   = (count != '0);
  assign next_ok   = (count >= CW'(2));

  always_comb begin
    win = head[31:0];
    case (pc[2:1])
      2'd0: win = head[31:0];
      2'd1: win = head[47:16];
      2'd2: win = head[63:32];
      2'd3: win = {(next_ok ? next[15:0] : 16'h0000), head[63:48]};
      default: win = head[31:0];
    endcase
  end

  assign is16 = (win[1:0] != 2'b11);

  // started keeps the request port quiet for the first edge after reset release.
  assign bus.sram_cs   = started && !bus.redirect_valid && ((count + CW'(in_flight)) < QD);
  assign bus.sram_addr = fetch_addr;

  assign bus.inst_valid = head_ok && (head_addr == pc[31:3]) &&
                          ((pc[2:1] != 2'b11) || is16 || next_ok);
  assign bus.inst_pc    = pc;
  assign bus.inst_win   = win;
  assign bus.inst_is16  = is16;

  assign grant   = bus.sram_cs && bus.sram_gnt;
  assign push    = in_flight && !bus.redirect_valid;
  assign consume = bus.inst_valid && bus.inst_ready && !bus.redirect_valid;
  assign pc_step = pc + (is16 ? 32'd2 : 32'd4);
  assign pop     = consume && (pc_step[31:3] != head_addr);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc          <= RESET_PC & ~32'h1;
      fetch_addr  <= RESET_PC[31:3];
      rd_ptr      <= '0;
      count       <= '0;
      in_flight   <= 1'b0;
      flight_addr <= '0;
      started     <= 1'b0;
    end else begin
      started <= 1'b1;
      if (bus.redirect_valid) begin
        // A return arriving this cycle is simply not pushed, which kills it.
        pc         <= bus.redirect_pc & ~32'h1;
        fetch_addr <= bus.redirect_pc[31:3];
        rd_ptr     <= '0;
        count      <= '0;
        in_flight  <= 1'b0;
      end else begin
        in_flight <= grant;
        if (grant) begin
          fetch_addr  <= fetch_addr + 29'd1;
          flight_addr <= fetch_addr;
        end
        if (consume) pc <= pc_step;
        if (pop) rd_ptr <= nx_ptr;
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_data[wr_ptr] <= bus.sram_rdata;
      q_addr[wr_ptr] <= flight_addr;
    end
  end
endmodule

// File: tb/tb_fetch_line_queue.sv
// Directed and randomized bench for fetch_line_queue: SRAM model, instruction scoreboard, fetch-address model.
module tb_fetch_line_queue;
  logic clk;
  logic rstn;
  fetch_line_queue_if bus ();

  fetch_line_queue #(.RESET_PC(32'h0000_0000), .QDEPTH(2)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // scoreboard entry: {is16, pc, win (upper half zero for 16-bit)}
  logic [64:0] exp_q[$];
  logic [63:0] mem [logic [28:0]];
  logic [28:0] exp_fetch;

  // per-cycle stimulus controls
  logic        do_redirect = 1'b0;
  logic [31:0] redir_pc    = 32'h0;
  logic        gnt_en      = 1'b0;
  logic        gnt_rand    = 1'b0;
  logic        auto_ready  = 1'b1;
  logic        man_ready   = 1'b0;
  logic        rst_val     = 1'b0;
  logic        ret_pending = 1'b0;
  logic [28:0] ret_line    = '0;

  // sampled DUT outputs
  logic        s_cs, s_valid, s_is16;
  logic [28:0] s_addr;
  logic [31:0] s_pc, s_win;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mem_rd(input logic [28:0] line);
    if (mem.exists(line)) return mem[line];
    return {35'h0, line} ^ 64'hFFFF_1234_FFFF_5678;
  endfunction

  task automatic put_hw(input logic [31:0] a, input logic [15:0] hw);
    logic [63:0] d;
    d = mem_rd(a[31:3]);
    d[{a[2:1], 4'b0000} +: 16] = hw;
    mem[a[31:3]] = d;
  endtask

  task automatic put_inst(input logic [31:0] a, input logic [31:0] ins);
    logic short_i;
    short_i = (ins[1:0] != 2'b11);
    put_hw(a, ins[15:0]);
    if (!short_i) put_hw(a + 32'd2, ins[31:16]);
    exp_q.push_back({short_i, a, (short_i ? {16'h0000, ins[15:0]} : ins)});
  endtask

  // driver: one clock cycle, inputs applied at negedge, outputs sampled 1 time unit later
  task automatic cycle();
    logic [64:0] e;
    logic        g;
    @(negedge clk);
    rstn               = rst_val;
    bus.redirect_valid = do_redirect;
    bus.redirect_pc    = redir_pc;
    g                  = gnt_rand ? 1'($urandom_range(0, 1)) : gnt_en;
    bus.sram_gnt       = g;
    bus.sram_rdata     = ret_pending ? mem_rd(ret_line) : {$urandom, $urandom};
    bus.inst_ready     = auto_ready ? (exp_q.size() != 0) : man_ready;
    #1;
    s_cs    = bus.sram_cs;
    s_addr  = bus.sram_addr;
    s_valid = bus.inst_valid;
    s_pc    = bus.inst_pc;
    s_win   = bus.inst_win;
    s_is16  = bus.inst_is16;
    if (!rst_val) begin
      chk("reset_cs", s_cs, 0);
      chk("reset_valid", s_valid, 0);
      exp_fetch   = 29'h0;
      ret_pending = 1'b0;
    end else begin
      if (do_redirect) begin
        chk("redirect_cs", s_cs, 0);
        exp_q.delete();
        exp_fetch = redir_pc[31:3];
      end
      if (s_cs && g) begin
        chk("sram_addr", s_addr, exp_fetch);
        exp_fetch = exp_fetch + 29'd1;
      end
      ret_pending = s_cs && g;
      ret_line    = s_addr;
      if (s_valid && bus.inst_ready && !do_redirect) begin
        chk("inst_unexpected", 64'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("inst_pc", s_pc, e[63:32]);
          chk("inst_is16", s_is16, e[64]);
          chk("inst_win", (e[64] ? {16'h0000, s_win[15:0]} : s_win), e[31:0]);
        end
      end
    end
    do_redirect = 1'b0;
  endtask

  task automatic redirect_to(input logic [31:0] p);
    do_redirect = 1'b1;
    redir_pc    = p;
    cycle();
  endtask

  task automatic drain(input int budget);
    auto_ready = 1'b1;
    for (int i = 0; i < budget && exp_q.size() != 0; i++) cycle();
    chk("drain_timeout", 64'(exp_q.size()), 0);
  endtask

  task automatic prog_boot();
    put_inst(32'h0, 32'h1111_0003);
    put_inst(32'h4, 32'h2222_0007);
    put_inst(32'h8, 32'h3333_000B);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation watchdog expired");
  end

  initial begin
    rstn               = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.sram_gnt       = 1'b0;
    bus.sram_rdata     = 64'h0;
    bus.inst_ready     = 1'b0;
    exp_fetch          = 29'h0;

    // Test 1: reset and boot sequence from address 0
    prog_boot();
    gnt_en = 1'b1;
    rst_val = 1'b0;
    cycle();
    cycle();
    rst_val = 1'b1;
    cycle();
    chk("t1_cs_at_release", s_cs, 0);
    cycle();
    chk("t1_cs_first", s_cs, 1);
    chk("t1_addr0", s_addr, 29'h0);
    cycle();
    chk("t1_cs_second", s_cs, 1);
    chk("t1_addr1", s_addr, 29'h1);
    chk("t1_valid_early", s_valid, 0);
    cycle();
    chk("t1_valid_two_after_grant", s_valid, 1);
    drain(40);

    // Test 2: 32-bit instruction straddling lines 0x20/0x21
    gnt_en = 1'b0;
    redirect_to(32'h0000_0106);
    put_inst(32'h0000_0106, 32'hABCD_0003);
    put_inst(32'h0000_010A, 32'h0000_4001);
    gnt_en = 1'b1;
    cycle();
    gnt_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t2_no_valid_without_next", s_valid, 0);
    end
    gnt_en = 1'b1;
    drain(40);

    // Test 3: mixed 16/32-bit stream crossing a line at 0x208
    redirect_to(32'h0000_0200);
    put_inst(32'h0000_0200, 32'h0000_1111);
    put_inst(32'h0000_0202, 32'hA5A5_0013);
    put_inst(32'h0000_0206, 32'h0000_1112);
    put_inst(32'h0000_0208, 32'hB6B6_0033);
    put_inst(32'h0000_020C, 32'h0000_1114);
    drain(40);

    // Test 4: redirect in the cycle the read of line 0x31 returns
    for (int k = 0; k < 4; k++) put_hw(32'h0000_0188 + 32'(k * 2), 16'h5555);
    auto_ready = 1'b0;
    man_ready  = 1'b1;
    gnt_en     = 1'b1;
    redirect_to(32'h0000_0188);
    cycle();
    chk("t4_grant_line31", s_cs, 1);
    redirect_to(32'h0000_0400);
    put_inst(32'h0000_0400, 32'h7777_0043);
    put_inst(32'h0000_0404, 32'h0000_0002);
    cycle();
    chk("t4_cs_after_redirect", s_cs, 1);
    chk("t4_addr_after_redirect", s_addr, 29'h80);
    chk("t4_no_stale_valid", s_valid, 0);
    drain(40);

    // Test 5: grant stall, then full queue with ready low
    auto_ready = 1'b0;
    man_ready  = 1'b0;
    gnt_en     = 1'b0;
    redirect_to(32'h0000_0600);
    put_inst(32'h0000_0600, 32'h1357_0013);
    put_inst(32'h0000_0604, 32'h2468_0023);
    put_inst(32'h0000_0608, 32'h0000_0005);
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("t5_cs_while_stalled", s_cs, 1);
      chk("t5_addr_held", s_addr, 29'hC0);
    end
    gnt_en = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    gnt_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("t5_cs_full", s_cs, 0);
      chk("t5_valid_held", s_valid, 1);
      chk("t5_pc_held", s_pc, 32'h0000_0600);
      chk("t5_win_held", s_win, 32'h1357_0013);
    end
    gnt_en = 1'b1;
    drain(40);

    // Test 6: asynchronous reset while a read is in flight
    auto_ready = 1'b0;
    man_ready  = 1'b0;
    redirect_to(32'h0000_0800);
    cycle();
    chk("t6_grant_before_reset", s_cs, 1);
    rst_val = 1'b0;
    cycle();
    cycle();
    rst_val = 1'b1;
    cycle();
    chk("t6_cs_at_release", s_cs, 0);
    chk("t6_queue_empty", s_valid, 0);
    prog_boot();
    drain(40);

    // Random stream with random grants
    gnt_rand = 1'b1;
    redirect_to(32'h0000_0A00);
    begin
      logic [31:0] a;
      logic [31:0] ins;
      a = 32'h0000_0A00;
      for (int i = 0; i < 24; i++) begin
        ins = $urandom;
        if ($urandom_range(0, 1) == 1) ins[1:0] = 2'b11;
        else ins[1:0] = 2'($urandom_range(0, 2));
        put_inst(a, ins);
        a = a + ((ins[1:0] == 2'b11) ? 32'd4 : 32'd2);
      end
    end
    drain(600);
    gnt_rand = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
